serial_101_tx: RTL and testbench

- Transmitter counterpart to the "101" Moore sequence detector.
- Accepts a parallel word over a valid/ready handshake and serialises it onto a single line as one frame: preamble, data, guard.
  - Preamble: the fixed marker 1,0,1.
  - Data: WIDTH bits, MSB first.
  - Guard: GUARD_BITS zeros, so the detector's FSM returns to SAD between frames.
- Drives the D input of the detector in lab benches and demo tops.

---
 rtl/serial_101_pkg.sv | 27 ++
 rtl/serial_bit_timer.sv | 40 ++++
 rtl/serial_101_tx.sv | 156 +++++++++++++++
 tb/tb_serial_101_tx.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_101_pkg.sv
// serial_101_pkg
// Shared definitions for the serial "101" frame transmitter:
//   - FSM state encoding (also exported on state_dbg)
//   - preamble marker and its length
//   - counter width helpers
package serial_101_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRE   = 2'd1,
    ST_DATA  = 2'd2,
    ST_GUARD = 2'd3
  } state_e;

  localparam logic [2:0] PREAMBLE = 3'b101;
  localparam int         PRE_LEN  = 3;

  // Bits needed to hold a counter running 0..max_count-1, never below 1.
  function automatic int cnt_width(input int max_count);
    return (max_count <= 2) ? 1 : $clog2(max_count);
  endfunction

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/serial_bit_timer.sv
// serial_bit_timer
// Divides clk down to the serial bit rate. The divider runs 0..BIT_DIV-1
// and bit_tick is high while it sits on its last count, so each serial bit
// lasts exactly BIT_DIV cycles. restart re-aligns the divider to the
// accept edge so the first bit of a frame gets its full length.
// Ports:
//   clk       in   system clock
//   _rst      in   asynchronous reset, active-low
//   restart   in   clear the divider (asserted on the accept edge)
//   bit_tick  out  current bit ends on the next rising edge
module serial_bit_timer
  import serial_101_pkg::*;
#(
  parameter int BIT_DIV = 1
) (
  input  logic clk,
  input  logic _rst,
  input  logic restart,
  output logic bit_tick
);

  localparam int             DW   = cnt_width(BIT_DIV);
  localparam logic [DW-1:0]  LAST = DW'(BIT_DIV - 1);

  logic [DW-1:0] r_div;

  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      r_div <= '0;
    end else if (restart || (r_div == LAST)) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + DW'(1);
    end
  end

  // With BIT_DIV=1 the divider never leaves 0, so every cycle is a tick.
  assign bit_tick = (r_div == LAST);

endmodule

// File: rtl/serial_101_tx.sv
// serial_101_tx
// Takes a parallel word over valid/ready and sends one frame on sout:
// preamble 1,0,1, then the word MSB first, then GUARD_BITS zeros so a
// downstream "101" detector falls back to its start state between frames.
// Ports:
//   clk        in   system clock
//   _rst       in   asynchronous reset, active-low
//   data       in   word to send, sampled on the accept edge only
//   valid      in   a word is offered
//   ready      out  idle, a word can be accepted
//   sout       out  registered serial line
//   busy       out  frame in progress
//   done       out  one-cycle pulse after the frame returns to idle
//   state_dbg  out  current FSM state (IDLE=0, PRE=1, DATA=2, GUARD=3)
//
// state | meaning
// IDLE  | line low, waiting for valid
// PRE   | sending the 1,0,1 marker
// DATA  | sending the word MSB first
// GUARD | sending trailing zeros
module serial_101_tx
  import serial_101_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int BIT_DIV    = 1,
  parameter int GUARD_BITS = 2
) (
  input  logic             clk,
  input  logic             _rst,
  input  logic [WIDTH-1:0] data,
  input  logic             valid,
  output logic             ready,
  output logic             sout,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state_dbg
);

  localparam int MAX_BITS = max_of(max_of(PRE_LEN, WIDTH), GUARD_BITS);
  localparam int BW       = cnt_width(MAX_BITS);

  state_e           r_state,  w_state_nxt;
  logic [WIDTH-1:0] r_shreg,  w_shreg_nxt;
  logic [BW-1:0]    r_bitcnt, w_bitcnt_nxt;
  logic             r_sout,   w_sout_nxt;
  logic             r_done,   w_done_nxt;
  logic             w_accept;
  logic             w_tick;
  logic [2:0]       w_pre_sh;

  assign w_accept = valid && (r_state == ST_IDLE);

  serial_bit_timer #(
    .BIT_DIV (BIT_DIV)
  ) u_timer (
    .clk      (clk),
    ._rst     (_rst),
    .restart  (w_accept),
    .bit_tick (w_tick)
  );

  // Marker bit that follows the one currently on the line lands in the MSB.
  assign w_pre_sh = PREAMBLE << (r_bitcnt + BW'(1));

  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      r_state  <= ST_IDLE;
      r_shreg  <= '0;
      r_bitcnt <= '0;
      r_sout   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_shreg  <= w_shreg_nxt;
      r_bitcnt <= w_bitcnt_nxt;
      r_sout   <= w_sout_nxt;
      r_done   <= w_done_nxt;
    end
  end

  // sout is registered, so each branch loads the bit that must be on the
  // line during the next bit period.
  always_comb begin
    w_state_nxt  = r_state;
    w_shreg_nxt  = r_shreg;
    w_bitcnt_nxt = r_bitcnt;
    w_sout_nxt   = r_sout;
    w_done_nxt   = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_sout_nxt = 1'b0;
        if (valid) begin
          w_state_nxt  = ST_PRE;
          w_shreg_nxt  = data;
          w_bitcnt_nxt = '0;
          w_sout_nxt   = PREAMBLE[PRE_LEN-1];
        end
      end

      ST_PRE: begin
        if (w_tick) begin
          if (r_bitcnt == BW'(PRE_LEN - 1)) begin
            w_state_nxt  = ST_DATA;
            w_bitcnt_nxt = '0;
            w_sout_nxt   = r_shreg[WIDTH-1];
            w_shreg_nxt  = r_shreg << 1;
          end else begin
            w_bitcnt_nxt = r_bitcnt + BW'(1);
            w_sout_nxt   = w_pre_sh[PRE_LEN-1];
          end
        end
      end

      ST_DATA: begin
        if (w_tick) begin
          if (r_bitcnt == BW'(WIDTH - 1)) begin
            w_state_nxt  = ST_GUARD;
            w_bitcnt_nxt = '0;
            w_sout_nxt   = 1'b0;
          end else begin
            w_bitcnt_nxt = r_bitcnt + BW'(1);
            w_sout_nxt   = r_shreg[WIDTH-1];
            w_shreg_nxt  = r_shreg << 1;
          end
        end
      end

      ST_GUARD: begin
        w_sout_nxt = 1'b0;
        if (w_tick) begin
          if (r_bitcnt == BW'(GUARD_BITS - 1)) begin
            w_state_nxt  = ST_IDLE;
            w_bitcnt_nxt = '0;
            w_done_nxt   = 1'b1;
          end else begin
            w_bitcnt_nxt = r_bitcnt + BW'(1);
          end
        end
      end

      default: begin
        w_state_nxt  = ST_IDLE;
        w_bitcnt_nxt = '0;
        w_sout_nxt   = 1'b0;
      end
    endcase
  end

  assign ready     = (r_state == ST_IDLE);
  assign busy      = (r_state != ST_IDLE);
  assign sout      = r_sout;
  assign done      = r_done;
  assign state_dbg = r_state;

endmodule

// File: tb/tb_serial_101_tx.sv
module tb_serial_101_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] data_a  [2];
  logic       valid_a [2];
  logic       ready_w [2];
  logic       sout_w  [2];
  logic       busy_w  [2];
  logic       done_w  [2];
  logic [1:0] st_w    [2];

  always #5 clk = ~clk;

  serial_101_tx #(.WIDTH(8), .BIT_DIV(1), .GUARD_BITS(2)) dut (
    .clk(clk), ._rst(rst_n), .data(data_a[0]), .valid(valid_a[0]),
    .ready(ready_w[0]), .sout(sout_w[0]), .busy(busy_w[0]),
    .done(done_w[0]), .state_dbg(st_w[0])
  );

  serial_101_tx #(.WIDTH(8), .BIT_DIV(3), .GUARD_BITS(2)) dut3 (
    .clk(clk), ._rst(rst_n), .data(data_a[1]), .valid(valid_a[1]),
    .ready(ready_w[1]), .sout(sout_w[1]), .busy(busy_w[1]),
    .done(done_w[1]), .state_dbg(st_w[1])
  );

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_q0[$];
  logic [7:0] exp_q1[$];

  int acc_cnt  [2] = '{0, 0};
  int done_cnt [2] = '{0, 0};
  int last_done[2] = '{0, 0};
  int gap_last [2] = '{0, 0};
  int ncap     [2] = '{0, 0};
  bit cap_on   [2] = '{0, 0};
  bit rdy_bad  [2] = '{0, 0};
  logic [63:0] got[2];
  int cyc   = 0;
  int hits0 = 0;
  logic [2:0] win = 3'b000;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Reference frame: marker 1,0,1, the word MSB first, two zeros; each
  // frame bit repeated div times, earliest sample in bit 0.
  function automatic logic [63:0] model_frame(input logic [7:0] d, input int div);
    bit fb[$];
    logic [63:0] e;
    int p;
    fb = {1'b1, 1'b0, 1'b1};
    for (int i = 7; i >= 0; i--) fb.push_back(d[i]);
    fb.push_back(1'b0);
    fb.push_back(1'b0);
    e = '0;
    p = 0;
    foreach (fb[j]) for (int r = 0; r < div; r++) begin
      e[p] = fb[j];
      p++;
    end
    return e;
  endfunction

  // Monitor: capture each frame while busy, check it when done pulses.
  always @(negedge clk) begin
    logic [7:0] d;
    int div;
    int n;
    cyc++;
    if (rst_n) begin
      win = {win[1:0], sout_w[0]};
      if (win == 3'b101) hits0++;
    end else begin
      win = 3'b000;
    end
    for (int k = 0; k < 2; k++) begin
      div = (k == 0) ? 1 : 3;
      if (!rst_n) begin
        cap_on[k] = 1'b0;
      end else begin
        if (busy_w[k] && !cap_on[k]) begin
          cap_on[k]   = 1'b1;
          ncap[k]     = 0;
          got[k]      = '0;
          rdy_bad[k]  = 1'b0;
          gap_last[k] = cyc - last_done[k];
          chk("start_state", {62'd0, st_w[k]}, 64'd1);
        end
        if (cap_on[k] && busy_w[k]) begin
          if (ncap[k] < 64) got[k][ncap[k]] = sout_w[k];
          ncap[k]++;
          if (ready_w[k]) rdy_bad[k] = 1'b1;
        end
        if (done_w[k]) begin
          done_cnt[k]++;
          last_done[k] = cyc;
          chk("done_in_frame", {63'd0, cap_on[k]}, 64'd1);
          n = (k == 0) ? exp_q0.size() : exp_q1.size();
          chk("exp_available", {63'd0, (n != 0)}, 64'd1);
          if (n != 0) begin
            d = (k == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            chk("frame_len", ncap[k], 13 * div);
            chk("frame_bits", got[k], model_frame(d, div));
            chk("ready_low_in_frame", {63'd0, rdy_bad[k]}, 64'd0);
            chk("done_cycle_lines", {61'd0, sout_w[k], ready_w[k], busy_w[k]}, 64'b010);
          end
          cap_on[k] = 1'b0;
        end else if (cap_on[k] && !busy_w[k]) begin
          chk("frame_end_done", {63'd0, done_w[k]}, 64'd1);
          cap_on[k] = 1'b0;
        end
      end
    end
  end

  task automatic send(input int k, input logic [7:0] d, input bit hold);
    bit acc;
    acc = 1'b0;
    @(negedge clk);
    data_a[k]  = d;
    valid_a[k] = 1'b1;
    for (int n = 0; n < 500; n++) begin
      acc = ready_w[k];
      @(posedge clk);
      if (acc) break;
      @(negedge clk);
    end
    if (acc) begin
      if (k == 0) exp_q0.push_back(d); else exp_q1.push_back(d);
      acc_cnt[k]++;
    end else begin
      chk("accept_timeout", {63'd0, acc}, 64'd1);
    end
    #1;
    if (!hold) valid_a[k] = 1'b0;
  endtask

  task automatic drain(input int k);
    int n;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      n = (k == 0) ? exp_q0.size() : exp_q1.size();
      if (n == 0 && !cap_on[k]) break;
    end
    @(negedge clk);
    n = (k == 0) ? exp_q0.size() : exp_q1.size();
    chk("drain", n + int'(cap_on[k]), 0);
  endtask

  initial begin
    bit quiet;
    int h0;
    int d0;
    int gap;
    logic [7:0] rd;

    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      data_a[k]  = 8'h00;
      valid_a[k] = 1'b0;
    end
    #12;
    for (int k = 0; k < 2; k++)
      chk("reset_state", {58'd0, sout_w[k], busy_w[k], done_w[k], ready_w[k], st_w[k]}, 64'b000100);
    #10 rst_n = 1'b1;

    // Directed A5 frame on both divider settings.
    send(0, 8'hA5, 1'b0);
    drain(0);
    send(1, 8'hA5, 1'b0);
    drain(1);

    // Held valid: FF then 00 back to back, one idle cycle between frames.
    repeat (3) @(negedge clk);
    h0 = hits0;
    send(0, 8'hFF, 1'b1);
    send(0, 8'h00, 1'b0);
    drain(0);
    chk("b2b_gap", gap_last[0], 1);
    chk("detector_hits", hits0 - h0, 2);

    // Data change and valid pulse while busy are ignored.
    d0 = done_cnt[0];
    send(0, 8'h3C, 1'b0);
    repeat (4) @(negedge clk);
    data_a[0]  = 8'hC3;
    valid_a[0] = 1'b1;
    @(negedge clk);
    valid_a[0] = 1'b0;
    data_a[0]  = 8'h00;
    drain(0);
    quiet = 1'b1;
    repeat (15) begin
      @(negedge clk);
      if (busy_w[0]) quiet = 1'b0;
    end
    chk("no_second_frame", {63'd0, quiet}, 64'd1);
    chk("one_done", done_cnt[0] - d0, 1);

    // Asynchronous reset in the middle of a frame.
    send(0, 8'h5A, 1'b0);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("reset_midframe", {58'd0, sout_w[0], busy_w[0], done_w[0], ready_w[0], st_w[0]}, 64'b000100);
    exp_q0.delete();
    acc_cnt[0]--;
    @(negedge clk);
    #2 rst_n = 1'b1;
    quiet = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (sout_w[0] || busy_w[0] || done_w[0]) quiet = 1'b0;
    end
    chk("quiet_after_reset", {63'd0, quiet}, 64'd1);

    // Randomised traffic, occasionally back to back.
    for (int i = 0; i < 200; i++) begin
      rd  = 8'($urandom);
      gap = int'($urandom_range(0, 3));
      send(0, rd, (gap == 0));
      repeat (gap) @(negedge clk);
    end
    valid_a[0] = 1'b0;
    drain(0);
    for (int i = 0; i < 20; i++) begin
      rd  = 8'($urandom);
      gap = int'($urandom_range(0, 2));
      send(1, rd, (gap == 0));
      repeat (gap) @(negedge clk);
    end
    valid_a[1] = 1'b0;
    drain(1);

    repeat (5) @(negedge clk);
    chk("done_vs_accept_div1", done_cnt[0], acc_cnt[0]);
    chk("done_vs_accept_div3", done_cnt[1], acc_cnt[1]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
